// File: rtl/ext_bus_pkg.sv
// ext_bus_pkg: shared types and constants for the external bus controller
package ext_bus_pkg;
   localparam int EB_CS_BITS       = 2;
   localparam int EB_CE_BITS       = 1 << EB_CS_BITS;
   localparam int EB_ADDR_BITS     = 24;
   localparam int EB_DATA_BITS     = 32;
   localparam int EB_CNT_BITS      = 4;
   localparam int EB_REQ_ADDR_BITS = EB_CS_BITS + EB_ADDR_BITS;
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} eb_state_t;
   function automatic logic [EB_CE_BITS-1:0] eb_cs_onehot(input logic [EB_CS_BITS-1:0] cs);
      return EB_CE_BITS'(1) << cs;
   endfunction
endpackage

// File: rtl/ext_bus_if.sv
// ext_bus_if: requester handshakes plus the active-high external bus signals
interface ext_bus_if;
   import ext_bus_pkg::*;
   logic                        req0_valid;
   logic                        req0_write;
   logic [EB_REQ_ADDR_BITS-1:0] req0_address;
   logic [EB_DATA_BITS-1:0]     req0_wdata;
   logic                        req0_done;
   logic                        req1_valid;
   logic                        req1_write;
   logic [EB_REQ_ADDR_BITS-1:0] req1_address;
   logic [EB_DATA_BITS-1:0]     req1_wdata;
   logic                        req1_done;
   logic [EB_DATA_BITS-1:0]     rdata;
   logic [EB_CE_BITS-1:0]       ext_bus_ce;
   logic                        ext_bus_oe;
   logic                        ext_bus_we;
   logic [EB_ADDR_BITS-1:0]     ext_bus_address;
   logic [EB_DATA_BITS-1:0]     ext_bus_write_data;
   logic                        ext_bus_write_data_enable;
   logic [EB_DATA_BITS-1:0]     ext_bus_read_data;
   modport master (
      input  req0_valid, req0_write, req0_address, req0_wdata,
      input  req1_valid, req1_write, req1_address, req1_wdata,
      input  ext_bus_read_data,
      output req0_done, req1_done, rdata,
      output ext_bus_ce, ext_bus_oe, ext_bus_we, ext_bus_address,
      output ext_bus_write_data, ext_bus_write_data_enable
   );
   modport slave (
      output req0_valid, req0_write, req0_address, req0_wdata,
      output req1_valid, req1_write, req1_address, req1_wdata,
      output ext_bus_read_data,
      input  req0_done, req1_done, rdata,
      input  ext_bus_ce, ext_bus_oe, ext_bus_we, ext_bus_address,
      input  ext_bus_write_data, ext_bus_write_data_enable
   );
endinterface

// File: rtl/ext_bus_rr_arbiter.sv
// ext_bus_rr_arbiter: two-way round-robin grant; port 0 wins the first contention
module ext_bus_rr_arbiter (
   input  logic int_clock,
   input  logic int_reset,
   input  logic enable,
   input  logic req0,
   input  logic req1,
   output logic grant_valid,
   output logic grant_index
);
   logic last_grant;
   // Lone requester wins; on contention the port not granted last time wins
   always_comb begin
      grant_valid = enable & (req0 | req1);
      grant_index = (req0 & req1) ? ~last_grant : req1;
   end
   // Remember the most recent grant for fairness
   always_ff @(posedge int_clock or posedge int_reset) begin
      if (int_reset) last_grant <= 1'b1;
      else if (grant_valid) last_grant <= grant_index;
   end
endmodule

// File: rtl/ext_bus_controller.sv
// ext_bus_controller: arbitrates two requesters and sequences setup/strobe/hold bus cycles
module ext_bus_controller
   import ext_bus_pkg::*;
#(
   parameter int unsigned READ_STROBE_CYCLES  = 3,
   parameter int unsigned WRITE_STROBE_CYCLES = 2
) (
   input logic       int_clock,
   input logic       int_reset,
   ext_bus_if.master bus
);
   localparam logic [EB_CNT_BITS-1:0] RD_LOAD = EB_CNT_BITS'(READ_STROBE_CYCLES - 1);
   localparam logic [EB_CNT_BITS-1:0] WR_LOAD = EB_CNT_BITS'(WRITE_STROBE_CYCLES - 1);
   eb_state_t                   state, state_next;
   logic [EB_CNT_BITS-1:0]      count, count_next;
   logic                        grant_valid, grant_index;
   logic                        txn_write, txn_port;
   logic [EB_REQ_ADDR_BITS-1:0] txn_address;
   logic [EB_DATA_BITS-1:0]     txn_wdata;
   logic                        sel_write, busy_next;
   logic [EB_REQ_ADDR_BITS-1:0] sel_address;
   logic [EB_DATA_BITS-1:0]     sel_wdata;
   ext_bus_rr_arbiter arbiter (
      .int_clock  (int_clock),
      .int_reset  (int_reset),
      .enable     (state == IDLE),
      .req0       (bus.req0_valid),
      .req1       (bus.req1_valid),
      .grant_valid(grant_valid),
      .grant_index(grant_index)
   );
   // State and strobe counter registers
   always_ff @(posedge int_clock or posedge int_reset) begin
      if (int_reset) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end
   // Next state: one SETUP cycle, N STROBE cycles counted down to zero, one HOLD cycle
   always_comb begin
      state_next = state;
      count_next = count;
      case (state)
         IDLE:    if (grant_valid) state_next = SETUP;
         SETUP: begin
            state_next = STROBE;
            count_next = txn_write ? WR_LOAD : RD_LOAD;
         end
         STROBE: begin
            count_next = count - 1'b1;
            if (count == '0) state_next = HOLD;
         end
         HOLD:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end
   // In IDLE the granted request feeds the output registers directly so CE is up in SETUP
   always_comb begin
      sel_write   = (state == IDLE) ? (grant_index ? bus.req1_write : bus.req0_write) : txn_write;
      sel_address = (state == IDLE) ? (grant_index ? bus.req1_address : bus.req0_address) : txn_address;
      sel_wdata   = (state == IDLE) ? (grant_index ? bus.req1_wdata : bus.req0_wdata) : txn_wdata;
      busy_next   = state_next != IDLE;
   end
   // Latch the granted request for the whole transaction; later changes by the requester are ignored
   always_ff @(posedge int_clock or posedge int_reset) begin
      if (int_reset) begin
         txn_write   <= 1'b0;
         txn_port    <= 1'b0;
         txn_address <= '0;
         txn_wdata   <= '0;
      end else if (state == IDLE && grant_valid) begin
         txn_write   <= sel_write;
         txn_port    <= grant_index;
         txn_address <= sel_address;
         txn_wdata   <= sel_wdata;
      end
   end
   // Registered bus outputs, computed from the next state so strobes never glitch
   always_ff @(posedge int_clock or posedge int_reset) begin
      if (int_reset) begin
         bus.ext_bus_ce                <= '0;
         bus.ext_bus_oe                <= 1'b0;
         bus.ext_bus_we                <= 1'b0;
         bus.ext_bus_address           <= '0;
         bus.ext_bus_write_data        <= '0;
         bus.ext_bus_write_data_enable <= 1'b0;
         bus.req0_done                 <= 1'b0;
         bus.req1_done                 <= 1'b0;
         bus.rdata                     <= '0;
      end else begin
         bus.ext_bus_ce                <= busy_next ? eb_cs_onehot(sel_address[EB_REQ_ADDR_BITS-1:EB_ADDR_BITS]) : '0;
         bus.ext_bus_address           <= busy_next ? sel_address[EB_ADDR_BITS-1:0] : '0;
         bus.ext_bus_write_data_enable <= busy_next & sel_write;
         bus.ext_bus_write_data        <= (busy_next & sel_write) ? sel_wdata : '0;
         bus.ext_bus_oe                <= (state_next == STROBE) & ~sel_write;
         bus.ext_bus_we                <= (state_next == STROBE) & sel_write;
         bus.req0_done                 <= (state_next == HOLD) & ~txn_port;
         bus.req1_done                 <= (state_next == HOLD) & txn_port;
         if (state == STROBE && count == '0 && !txn_write) bus.rdata <= bus.ext_bus_read_data;
      end
   end
endmodule

// File: tb/tb_ext_bus_controller.sv
// tb_ext_bus_controller: directed checks of arbitration, bus timing, rdata and reset
module tb_ext_bus_controller;
   logic int_clock = 1'b0;
   logic int_reset = 1'b1;
   int compared = 0;
   int mismatched = 0;
   int p, dt;
   logic [31:0] exp_rdata;

   ext_bus_if b ();
   ext_bus_if b2 ();

   ext_bus_controller #(.READ_STROBE_CYCLES(3), .WRITE_STROBE_CYCLES(2)) dut (
      .int_clock(int_clock), .int_reset(int_reset), .bus(b));
   ext_bus_controller #(.READ_STROBE_CYCLES(1), .WRITE_STROBE_CYCLES(2)) dut_short (
      .int_clock(int_clock), .int_reset(int_reset), .bus(b2));

   always #5 int_clock = ~int_clock;

   task automatic tick();
      @(posedge int_clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bchk(input string tag, input logic [3:0] ce, input logic oe, input logic we,
                       input logic wde, input logic d0, input logic d1);
      chk(tag, 32'({b.ext_bus_ce, b.ext_bus_oe, b.ext_bus_we, b.ext_bus_write_data_enable,
                    b.req0_done, b.req1_done}), 32'({ce, oe, we, wde, d0, d1}));
   endtask

   task automatic wait_done(output int port, output int cyc);
      port = -1;
      cyc = -1;
      for (int c = 0; c < 40; c++) begin
         chk("ce_onehot0", 32'($onehot0(b.ext_bus_ce)), 32'd1);
         if (b.req0_done | b.req1_done) begin
            chk("done_exclusive", 32'(b.req0_done & b.req1_done), 32'd0);
            port = b.req1_done ? 1 : 0;
            cyc = c;
            break;
         end
         tick();
      end
   endtask

   initial begin
      {b.req0_valid, b.req0_write, b.req0_address, b.req0_wdata} = '0;
      {b.req1_valid, b.req1_write, b.req1_address, b.req1_wdata} = '0;
      b.ext_bus_read_data = '0;
      {b2.req0_valid, b2.req0_write, b2.req0_address, b2.req0_wdata} = '0;
      {b2.req1_valid, b2.req1_write, b2.req1_address, b2.req1_wdata} = '0;
      b2.ext_bus_read_data = '0;
      repeat (2) @(posedge int_clock);
      #1 int_reset = 1'b0;
      bchk("reset_ctrl", 4'b0000, 0, 0, 0, 0, 0);
      chk("reset_addr", 32'(b.ext_bus_address), 32'h0);
      chk("reset_wdata", b.ext_bus_write_data, 32'h0);
      chk("reset_rdata", b.rdata, 32'h0);

      // single read on port 0
      b.req0_valid = 1'b1;
      b.req0_write = 1'b0;
      b.req0_address = 26'h1000040;
      b.ext_bus_read_data = 32'hDEADBEEF;
      bchk("t1_c0", 4'b0000, 0, 0, 0, 0, 0);
      tick();
      bchk("t1_setup", 4'b0010, 0, 0, 0, 0, 0);
      chk("t1_addr", 32'(b.ext_bus_address), 32'h000040);
      tick();
      for (int i = 2; i <= 4; i++) begin
         bchk("t1_strobe", 4'b0010, 1, 0, 0, 0, 0);
         tick();
      end
      bchk("t1_hold", 4'b0010, 0, 0, 0, 1, 0);
      chk("t1_rdata", b.rdata, 32'hDEADBEEF);
      b.req0_valid = 1'b0;
      b.ext_bus_read_data = 32'h0;
      tick();
      bchk("t1_idle", 4'b0000, 0, 0, 0, 0, 0);
      chk("t1_rdata_held", b.rdata, 32'hDEADBEEF);

      // single write on port 1
      b.req1_valid = 1'b1;
      b.req1_write = 1'b1;
      b.req1_address = 26'h3ABCDEF;
      b.req1_wdata = 32'h12345678;
      tick();
      bchk("t2_setup", 4'b1000, 0, 0, 1, 0, 0);
      chk("t2_addr", 32'(b.ext_bus_address), 32'hABCDEF);
      chk("t2_wdata", b.ext_bus_write_data, 32'h12345678);
      tick();
      for (int i = 2; i <= 3; i++) begin
         bchk("t2_strobe", 4'b1000, 0, 1, 1, 0, 0);
         tick();
      end
      bchk("t2_hold", 4'b1000, 0, 0, 1, 0, 1);
      chk("t2_hold_wdata", b.ext_bus_write_data, 32'h12345678);
      chk("t2_rdata", b.rdata, 32'hDEADBEEF);
      b.req1_valid = 1'b0;
      tick();
      bchk("t2_idle", 4'b0000, 0, 0, 0, 0, 0);

      // contention after reset: writes on port 0, reads on port 1
      int_reset = 1'b1;
      tick();
      int_reset = 1'b0;
      exp_rdata = 32'h0;
      b.req0_valid = 1'b1;
      b.req0_write = 1'b1;
      b.req0_address = 26'h0000010;
      b.req0_wdata = 32'h00000055;
      b.req1_valid = 1'b1;
      b.req1_write = 1'b0;
      b.req1_address = 26'h2000020;
      for (int i = 0; i < 8; i++) begin
         b.ext_bus_read_data = 32'hA5A50000 + 32'(i);
         chk("t3_idle_gap", 32'(b.ext_bus_ce), 32'h0);
         wait_done(p, dt);
         chk("t3_grant_order", p, i % 2);
         chk("t3_latency", dt, (i % 2) ? 5 : 4);
         if (i % 2 == 1) exp_rdata = 32'hA5A50000 + 32'(i);
         chk("t3_rdata", b.rdata, exp_rdata);
         tick();
      end

      // port 1 alone, then port 0 joins
      b.req0_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         b.ext_bus_read_data = 32'h11110000 + 32'(k);
         wait_done(p, dt);
         chk("t4_port1_only", p, 1);
         chk("t4_no_stall", dt, 5);
         chk("t4_rdata", b.rdata, 32'h11110000 + 32'(k));
         if (k == 2) b.req0_valid = 1'b1;
         tick();
      end
      wait_done(p, dt);
      chk("t4_port0_next", p, 0);
      chk("t4_port0_latency", dt, 4);
      b.req0_valid = 1'b0;
      b.req1_valid = 1'b0;
      tick();

      // asynchronous reset in the middle of a write strobe
      b.req0_valid = 1'b1;
      tick();
      tick();
      bchk("t5_strobe", 4'b0001, 0, 1, 1, 0, 0);
      #2 int_reset = 1'b1;
      #1 bchk("t5_async_drop", 4'b0000, 0, 0, 0, 0, 0);
      tick();
      bchk("t5_in_reset", 4'b0000, 0, 0, 0, 0, 0);
      b.req1_valid = 1'b1;
      int_reset = 1'b0;
      wait_done(p, dt);
      chk("t5_regrant_port0", p, 0);
      chk("t5_regrant_latency", dt, 4);
      b.req0_valid = 1'b0;
      b.req1_valid = 1'b0;
      tick();

      // one-cycle read strobe instance
      b2.req0_valid = 1'b1;
      b2.req0_write = 1'b0;
      b2.req0_address = 26'h0000004;
      b2.ext_bus_read_data = 32'h0BADF00D;
      chk("t6_c0", 32'({b2.ext_bus_ce, b2.ext_bus_oe, b2.req0_done}), 32'({4'b0000, 1'b0, 1'b0}));
      tick();
      chk("t6_setup", 32'({b2.ext_bus_ce, b2.ext_bus_oe, b2.req0_done}), 32'({4'b0001, 1'b0, 1'b0}));
      tick();
      chk("t6_strobe", 32'({b2.ext_bus_ce, b2.ext_bus_oe, b2.req0_done}), 32'({4'b0001, 1'b1, 1'b0}));
      tick();
      chk("t6_hold", 32'({b2.ext_bus_ce, b2.ext_bus_oe, b2.req0_done}), 32'({4'b0001, 1'b0, 1'b1}));
      chk("t6_rdata", b2.rdata, 32'h0BADF00D);
      b2.req0_valid = 1'b0;
      tick();
      chk("t6_idle", 32'({b2.ext_bus_ce, b2.ext_bus_oe, b2.req0_done}), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
